// File: rtl/ram_loader.sv
// Byte-serial loader: assembles little-endian bytes into 32-bit words and writes them
// to the data RAM while holding the CPU halted. Optional trailing XOR check: RAM_LOADER_CSUM_EN.
module ram_loader #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [CNT_W-1:0]  i_count,
    input  logic [7:0]        i_in_data,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [31:0]       o_ram_din,
    output logic [3:0]        o_ram_sel,
    output logic              o_halt,
    output logic              o_done,
    output logic              o_err,
    output logic [CNT_W-1:0]  o_words
);

    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
`ifdef RAM_LOADER_CSUM_EN
        S_CSUM  = 3'd3,
`endif
        S_FIN   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_words;
    logic [1:0]        r_idx;
    logic [23:0]       r_asm;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [31:0]       r_ram_din;
    logic              w_hs;
    logic              w_last_word;
    logic [CNT_W-1:0]  w_count_sat;

    assign w_hs        = o_in_ready & i_in_valid;
    assign w_last_word = (r_words + CNT_W'(1)) == r_count;
    assign w_count_sat = (i_count > MAX_WORDS) ? MAX_WORDS : i_count;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = (i_count == '0) ? S_FIN : S_RECV;
            S_RECV:  if (w_hs && r_idx == 2'd3) w_next = S_WRITE;
            S_WRITE: begin
                if (w_last_word) begin
`ifdef RAM_LOADER_CSUM_EN
                    w_next = S_CSUM;
`else
                    w_next = S_FIN;
`endif
                end else begin
                    w_next = S_RECV;
                end
            end
`ifdef RAM_LOADER_CSUM_EN
            S_CSUM:  if (w_hs) w_next = S_FIN;
`endif
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register only
    always_comb begin
        o_in_ready = 1'b0;
        o_ram_we   = 1'b0;
        o_halt     = 1'b1;
        o_done     = 1'b0;
        case (r_state)
            S_IDLE:  o_halt     = 1'b0;
            S_RECV:  o_in_ready = 1'b1;
            S_WRITE: o_ram_we   = 1'b1;
`ifdef RAM_LOADER_CSUM_EN
            S_CSUM:  o_in_ready = 1'b1;
`endif
            S_FIN:   o_done     = 1'b1;
            default: ;
        endcase
    end

    // Datapath: word assembly, address generation and word counting
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_base     <= '0;
            r_count    <= '0;
            r_words    <= '0;
            r_idx      <= '0;
            r_asm      <= '0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_base  <= i_base;
                        r_count <= w_count_sat;
                        r_words <= '0;
                        r_idx   <= '0;
                    end
                end
                S_RECV: begin
                    if (w_hs) begin
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_ram_din  <= {i_in_data, r_asm};
                            r_ram_addr <= r_base + r_words[ADDR_W-1:0];
                        end else begin
                            r_asm[{r_idx, 3'b000} +: 8] <= i_in_data;
                        end
                    end
                end
                S_WRITE: r_words <= r_words + CNT_W'(1);
                default: ;
            endcase
        end
    end

`ifdef RAM_LOADER_CSUM_EN
    logic [7:0] r_csum;
    logic       r_err;

    // Running XOR of accepted data bytes; err is sticky until the next accepted start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_csum <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && i_start) begin
                r_csum <= '0;
                r_err  <= 1'b0;
            end else if (r_state == S_RECV && w_hs) begin
                r_csum <= r_csum ^ i_in_data;
            end else if (r_state == S_CSUM && w_hs && i_in_data != r_csum) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    assign o_ram_addr = r_ram_addr;
    assign o_ram_din  = r_ram_din;
    assign o_ram_sel  = 4'hf;
    assign o_words    = r_words;

endmodule

// File: tb/tb_ram_loader.sv
// Directed testbench for ram_loader: builds with or without RAM_LOADER_CSUM_EN.
module tb_ram_loader;

    localparam int ADDR_W = 5;
    localparam int CNT_W  = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_start = 1'b0;
    logic [ADDR_W-1:0] i_base = '0;
    logic [CNT_W-1:0]  i_count = '0;
    logic [7:0]        i_in_data = '0;
    logic              i_in_valid = 1'b0;
    logic              o_in_ready;
    logic              o_ram_we;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [31:0]       o_ram_din;
    logic [3:0]        o_ram_sel;
    logic              o_halt;
    logic              o_done;
    logic              o_err;
    logic [CNT_W-1:0]  o_words;

    ram_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (i_start),
        .i_base     (i_base),
        .i_count    (i_count),
        .i_in_data  (i_in_data),
        .i_in_valid (i_in_valid),
        .o_in_ready (o_in_ready),
        .o_ram_we   (o_ram_we),
        .o_ram_addr (o_ram_addr),
        .o_ram_din  (o_ram_din),
        .o_ram_sel  (o_ram_sel),
        .o_halt     (o_halt),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_words    (o_words)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ticks    = 0;

    // Write monitor, sampled on the falling edge
    logic [ADDR_W-1:0] got_addr[$];
    logic [31:0]       got_din[$];
    int                we_cnt = 0;
    int                we_ready_viol = 0;

    always @(negedge clk) begin
        if (o_ram_we) begin
            got_addr.push_back(o_ram_addr);
            got_din.push_back(o_ram_din);
            we_cnt++;
            if (o_in_ready) we_ready_viol++;
        end
    end

    // Reference model of the expected write stream
    logic [ADDR_W-1:0] m_base;
    int                m_words;
    int                m_lane;
    logic [31:0]       m_word;
    logic [7:0]        m_csum;
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_din[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ticks++;
    endtask

    task automatic begin_load(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] cnt);
        i_start = 1'b1;
        i_base  = base;
        i_count = cnt;
        tick();
        i_start = 1'b0;
        ticks   = 0;
        m_base  = base;
        m_words = 0;
        m_lane  = 0;
        m_word  = '0;
        m_csum  = '0;
        exp_addr.delete();
        exp_din.delete();
        got_addr.delete();
        got_din.delete();
    endtask

    // Present one byte after gap idle cycles and hold it until accepted
    task automatic send_raw(input logic [7:0] b, input int gap);
        i_in_valid = 1'b0;
        repeat (gap) tick();
        i_in_valid = 1'b1;
        i_in_data  = b;
        for (int k = 0; k < 50 && !o_in_ready; k++) tick();
        if (!o_in_ready) check("in_ready timeout", o_in_ready, 1'b1);
        tick();
        i_in_valid = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] b, input int gap);
        send_raw(b, gap);
        m_word[8*m_lane +: 8] = b;
        m_csum = m_csum ^ b;
        m_lane++;
        if (m_lane == 4) begin
            exp_addr.push_back(m_base + ADDR_W'(m_words));
            exp_din.push_back(m_word);
            m_words++;
            m_lane = 0;
        end
    endtask

    task automatic wait_done();
        for (int k = 0; k < 60 && !o_done; k++) tick();
        check("done pulse", o_done, 1'b1);
    endtask

    task automatic finish_load(input int gap);
`ifdef RAM_LOADER_CSUM_EN
        send_raw(m_csum, gap);
`else
        repeat (gap) tick();
`endif
        wait_done();
    endtask

    task automatic check_writes(input string tag, input int n_exp);
        check({tag, " write count"}, got_addr.size(), n_exp);
        for (int i = 0; i < n_exp && i < got_addr.size() && i < exp_addr.size(); i++) begin
            check($sformatf("%s addr[%0d]", tag, i), got_addr[i], exp_addr[i]);
            check($sformatf("%s din[%0d]", tag, i), got_din[i], exp_din[i]);
        end
    endtask

    initial begin
        int we_before;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst in_ready", o_in_ready, 1'b0);
        check("rst ram_we", o_ram_we, 1'b0);
        check("rst ram_addr", o_ram_addr, 0);
        check("rst ram_din", o_ram_din, 0);
        check("rst ram_sel", o_ram_sel, 4'hf);
        check("rst halt", o_halt, 1'b0);
        check("rst done", o_done, 1'b0);
        check("rst err", o_err, 1'b0);
        check("rst words", o_words, 0);
        rst_n = 1'b1;
        tick();

        // Single word at base 3
        begin_load(5'd3, 6'd1);
        check("t1 halt after start", o_halt, 1'b1);
        check("t1 in_ready in RECV", o_in_ready, 1'b1);
        send_data(8'h78, 0);
        send_data(8'h56, 0);
        send_data(8'h34, 0);
        send_data(8'h12, 0);
        check("t1 ram_we", o_ram_we, 1'b1);
        check("t1 in_ready in WRITE", o_in_ready, 1'b0);
        check("t1 ram_addr", o_ram_addr, 5'd3);
        check("t1 ram_din", o_ram_din, 32'h1234_5678);
        check("t1 ram_sel", o_ram_sel, 4'hf);
        finish_load(0);
        check("t1 words", o_words, 1);
        check("t1 ram_we in FIN", o_ram_we, 1'b0);
        tick();
        check("t1 halt after FIN", o_halt, 1'b0);
        check("t1 done one cycle", o_done, 1'b0);
        check("t1 err", o_err, 1'b0);
        check_writes("t1", 1);

        // Four words wrapping 30, 31, 0, 1 with a continuous stream
        begin_load(5'd30, 6'd4);
        for (int i = 0; i < 16; i++) send_data(8'(8'h10 + i), 0);
        finish_load(0);
`ifdef RAM_LOADER_CSUM_EN
        check("t2 cycles to done", ticks, 21);
`else
        check("t2 cycles to done", ticks, 20);
`endif
        check("t2 words", o_words, 4);
        check("t2 err", o_err, 1'b0);
        check("t2 addr[2] wraps", got_addr.size() > 2 ? got_addr[2] : 5'h1f, 5'd0);
        check("t2 din[3]", got_din.size() > 3 ? got_din[3] : 32'h0, 32'h1f1e_1d1c);
        check_writes("t2", 4);
        tick();

        // count = 0: straight to FIN, no write
        we_before = we_cnt;
        begin_load(5'd7, 6'd0);
        check("t3 done", o_done, 1'b1);
        check("t3 halt in FIN", o_halt, 1'b1);
        check("t3 ram_we", o_ram_we, 1'b0);
        tick();
        check("t3 done cleared", o_done, 1'b0);
        check("t3 halt cleared", o_halt, 1'b0);
        check("t3 no write", we_cnt, we_before);

        // Random gaps with a stray start mid-load
        begin_load(5'd5, 6'd3);
        for (int i = 0; i < 12; i++) begin
            send_data(8'(8'ha0 + i), $urandom_range(0, 3));
            if (i == 5) begin
                i_start = 1'b1;
                i_base  = 5'd20;
                i_count = 6'd1;
                tick();
                i_start = 1'b0;
                check("t4 stray start ignored", o_halt, 1'b1);
            end
        end
        finish_load($urandom_range(0, 3));
        check("t4 words", o_words, 3);
        check_writes("t4", 3);
        tick();

        // count above 32 saturates to 32 words
        begin_load(5'd0, 6'd40);
        for (int i = 0; i < 128; i++) send_data(8'(i * 7 + 1), 0);
        finish_load(0);
        check("t5 saturated words", o_words, 32);
        check_writes("t5", 32);
        tick();

        // Reset after two bytes, then a clean load
        begin_load(5'd9, 6'd2);
        send_data(8'h11, 0);
        send_data(8'h22, 0);
        we_before = we_cnt;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6 halt after reset", o_halt, 1'b0);
        check("t6 in_ready after reset", o_in_ready, 1'b0);
        check("t6 words after reset", o_words, 0);
        check("t6 ram_addr after reset", o_ram_addr, 0);
        check("t6 ram_din after reset", o_ram_din, 0);
        tick();
        tick();
        check("t6 no write after reset", we_cnt, we_before);
        begin_load(5'd9, 6'd1);
        send_data(8'hde, 0);
        send_data(8'had, 0);
        send_data(8'hbe, 0);
        send_data(8'hef, 0);
        finish_load(0);
        check("t6 clean words", o_words, 1);
        check("t6 clean din", got_din.size() > 0 ? got_din[0] : 32'h0, 32'hefbe_adde);
        check_writes("t6", 1);
        check("t6 in_ready never high in WRITE", we_ready_viol, 0);
        tick();

`ifdef RAM_LOADER_CSUM_EN
        // Checksum byte: 01^02^03^04 = 04
        begin_load(5'd2, 6'd1);
        send_data(8'h01, 0);
        send_data(8'h02, 0);
        send_data(8'h03, 0);
        send_data(8'h04, 0);
        send_raw(8'h04, 0);
        wait_done();
        check("t7 good csum err", o_err, 1'b0);
        tick();
        begin_load(5'd2, 6'd1);
        send_data(8'h01, 0);
        send_data(8'h02, 0);
        send_data(8'h03, 0);
        send_data(8'h04, 0);
        send_raw(8'h05, 0);
        wait_done();
        tick();
        check("t7 bad csum err", o_err, 1'b1);
        tick();
        tick();
        tick();
        check("t7 err sticky in IDLE", o_err, 1'b1);
        begin_load(5'd0, 6'd0);
        check("t7 err cleared by start", o_err, 1'b0);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
